// File: rtl/counter_stim_gen.sv
// ============================================================================
//  Module   : counter_stim_gen
//  Purpose  : Self-running ENABLE/MODO/D stimulus sequencer for the 4-bit
//             mode counter bench (load, +3, -1, +1, disabled window, done).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_stim_gen #(
    parameter int         CYCLES_PER_MODE = 16,
    parameter logic [3:0] LFSR_SEED       = 4'b1001
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       start,
    output logic       ENABLE,
    output logic [1:0] MODO,
    output logic [3:0] D,
    output logic       busy,
    output logic       done,
    output logic [2:0] phase
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_UP3   = 3'd2;
    localparam logic [2:0] c_DOWN1 = 3'd3;
    localparam logic [2:0] c_UP1   = 3'd4;
    localparam logic [2:0] c_DIS   = 3'd5;
    localparam logic [2:0] c_DONE  = 3'd6;

    localparam logic [1:0] c_MODO_UP3   = 2'b00;
    localparam logic [1:0] c_MODO_DOWN1 = 2'b01;
    localparam logic [1:0] c_MODO_UP1   = 2'b10;
    localparam logic [1:0] c_MODO_LOAD  = 2'b11;

    localparam logic [7:0] c_CNT_LAST = 8'(CYCLES_PER_MODE - 1);
    localparam logic [7:0] c_DIS_LAST = 8'd3;
    // An all-zero seed would lock the LFSR, so it is replaced by 0001.
    localparam logic [3:0] c_SEED = (LFSR_SEED == 4'd0) ? 4'b0001 : LFSR_SEED;

    logic [2:0] r_state;
    logic [3:0] r_lfsr;
    logic [7:0] r_cnt;
    logic [3:0] r_idx;

    logic [2:0] w_state_nxt;
    logic [7:0] w_last;
    logic       w_phase_end;
    logic       w_enter;
    logic [3:0] w_lfsr_step;
    logic [3:0] w_lfsr_nxt;
    logic [7:0] w_cnt_nxt;
    logic [3:0] w_idx_nxt;
    logic [3:0] w_idx_out;
    logic       w_enable_nxt;
    logic [1:0] w_modo_nxt;
    logic [3:0] w_d_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;

    assign phase = r_state;

    always_comb begin
        w_last      = (r_state == c_DIS) ? c_DIS_LAST : c_CNT_LAST;
        w_phase_end = (r_cnt == w_last);
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE, c_DONE: if (start)       w_state_nxt = c_LOAD;
            c_LOAD:         if (w_phase_end) w_state_nxt = c_UP3;
            c_UP3:          if (w_phase_end) w_state_nxt = c_DOWN1;
            c_DOWN1:        if (w_phase_end) w_state_nxt = c_UP1;
            c_UP1:          if (w_phase_end) w_state_nxt = c_DIS;
            c_DIS:          if (w_phase_end) w_state_nxt = c_DONE;
            default:                         w_state_nxt = c_IDLE;
        endcase
        w_enter     = (w_state_nxt != r_state);
        w_lfsr_step = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as phase and stay stable for the whole following cycle.
    always_comb begin
        w_cnt_nxt    = w_enter ? 8'd0 : r_cnt + 8'd1;
        w_idx_nxt    = w_enter ? 4'd1 : r_idx + 4'd1;
        w_idx_out    = w_enter ? 4'd0 : r_idx;
        w_lfsr_nxt   = r_lfsr;
        w_enable_nxt = 1'b0;
        w_modo_nxt   = c_MODO_UP3;
        w_d_nxt      = 4'd0;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        case (w_state_nxt)
            c_LOAD: begin
                w_enable_nxt = 1'b1;
                w_modo_nxt   = c_MODO_LOAD;
                w_d_nxt      = r_lfsr;
                w_lfsr_nxt   = w_lfsr_step;
                w_busy_nxt   = 1'b1;
            end
            c_UP3: begin
                w_enable_nxt = 1'b1;
                w_modo_nxt   = c_MODO_UP3;
                w_d_nxt      = w_idx_out;
                w_busy_nxt   = 1'b1;
            end
            c_DOWN1: begin
                w_enable_nxt = 1'b1;
                w_modo_nxt   = c_MODO_DOWN1;
                w_d_nxt      = w_idx_out;
                w_busy_nxt   = 1'b1;
            end
            c_UP1: begin
                w_enable_nxt = 1'b1;
                w_modo_nxt   = c_MODO_UP1;
                w_d_nxt      = w_idx_out;
                w_busy_nxt   = 1'b1;
            end
            c_DIS: begin
                w_modo_nxt   = c_MODO_LOAD;
                w_d_nxt      = r_lfsr;
                w_lfsr_nxt   = w_lfsr_step;
                w_busy_nxt   = 1'b1;
            end
            c_DONE: begin
                w_done_nxt   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state <= c_IDLE;
            r_lfsr  <= c_SEED;
            r_cnt   <= 8'd0;
            r_idx   <= 4'd0;
            ENABLE  <= 1'b0;
            MODO    <= 2'b00;
            D       <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            ENABLE  <= w_enable_nxt;
            MODO    <= w_modo_nxt;
            D       <= w_d_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_counter_stim_gen.sv
// ============================================================================
//  Module   : tb_counter_stim_gen
//  Purpose  : Directed self-checking bench for counter_stim_gen.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_counter_stim_gen;

    logic       clk = 1'b0;
    logic       RESET;
    logic       start;

    logic       a_en,  b_en,  z_en;
    logic [1:0] a_modo, b_modo, z_modo;
    logic [3:0] a_d,   b_d,   z_d;
    logic       a_busy, b_busy, z_busy;
    logic       a_done, b_done, z_done;
    logic [2:0] a_ph,  b_ph,  z_ph;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    counter_stim_gen #(.CYCLES_PER_MODE(16), .LFSR_SEED(4'b1001)) dut (
        .clk(clk), .RESET(RESET), .start(start),
        .ENABLE(a_en), .MODO(a_modo), .D(a_d),
        .busy(a_busy), .done(a_done), .phase(a_ph)
    );

    counter_stim_gen #(.CYCLES_PER_MODE(20), .LFSR_SEED(4'b1001)) dut20 (
        .clk(clk), .RESET(RESET), .start(start),
        .ENABLE(b_en), .MODO(b_modo), .D(b_d),
        .busy(b_busy), .done(b_done), .phase(b_ph)
    );

    counter_stim_gen #(.CYCLES_PER_MODE(16), .LFSR_SEED(4'b0000)) dut_s0 (
        .clk(clk), .RESET(RESET), .start(start),
        .ENABLE(z_en), .MODO(z_modo), .D(z_d),
        .busy(z_busy), .done(z_done), .phase(z_ph)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_en"},   int'(a_en),   0);
        check({tag, "_modo"}, int'(a_modo), 0);
        check({tag, "_d"},    int'(a_d),    0);
        check({tag, "_busy"}, int'(a_busy), 0);
        check({tag, "_done"}, int'(a_done), 0);
        check({tag, "_ph"},   int'(a_ph),   0);
    endtask

    logic [3:0] exp_l;
    int ep, em, ed, een;

    initial begin
        RESET = 1'b1;
        start = 1'b0;
        tick();
        tick();
        check_reset_vals("rst");
        RESET = 1'b0;
        tick();
        check("idle_ph", int'(a_ph), 0);
        start = 1'b1;
        tick();

        // Full N=16 run; a stray start pulse lands in UP3 and must be ignored.
        exp_l = 4'b1001;
        for (int c = 0; c < 68; c++) begin
            een = 1;
            if (c < 16)      begin ep = 1; em = 3; ed = int'(exp_l); end
            else if (c < 32) begin ep = 2; em = 0; ed = c - 16; end
            else if (c < 48) begin ep = 3; em = 1; ed = c - 32; end
            else if (c < 64) begin ep = 4; em = 2; ed = c - 48; end
            else             begin ep = 5; em = 3; ed = int'(exp_l); een = 0; end
            check("run_ph",   int'(a_ph),   ep);
            check("run_en",   int'(a_en),   een);
            check("run_modo", int'(a_modo), em);
            check("run_d",    int'(a_d),    ed);
            check("run_busy", int'(a_busy), 1);
            check("run_done", int'(a_done), 0);
            if (c < 16 || c >= 64) exp_l = {exp_l[2:0], exp_l[3] ^ exp_l[2]};
            if (c == 0)  check("seed0_d0", int'(z_d), 1);
            if (c == 1)  check("seed0_d1", int'(z_d), 2);
            if (c == 19) check("n20_load_end", int'(b_ph), 1);
            if (c >= 20 && c < 40) begin
                check("n20_ph", int'(b_ph), 2);
                check("n20_d",  int'(b_d),  (c - 20) % 16);
            end
            if (c == 40) check("n20_down1", int'(b_ph), 3);
            start = (c == 20);
            tick();
        end

        check("done_done", int'(a_done), 1);
        check("done_busy", int'(a_busy), 0);
        check("done_ph",   int'(a_ph),   6);
        check("done_en",   int'(a_en),   0);
        check("done_modo", int'(a_modo), 0);
        check("done_d",    int'(a_d),    0);
        tick();
        tick();
        check("done_held", int'(a_done), 1);

        // Back-to-back: held start restarts; LFSR continues, not reseeded.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_ph",   int'(a_ph),   1);
        check("b2b_d",    int'(a_d),    int'(exp_l));
        check("b2b_busy", int'(a_busy), 1);
        check("b2b_done", int'(a_done), 0);
        for (int i = 0; i < 32; i++) tick();
        check("b2b_down1", int'(a_ph), 3);

        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_reset_vals("midrst");
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("reseed_d",    int'(a_d),    9);
        check("reseed_ph",   int'(a_ph),   1);
        check("reseed_modo", int'(a_modo), 3);
        check("reseed_en",   int'(a_en),   1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/counter_stim_gen.md
# counter_stim_gen

Self-running stimulus generator for the 4-bit mode counter bench. It produces the `ENABLE`, `MODO` and `D` stimulus that the counter DUT and the scoreboard both consume. It walks a fixed sequence of mode phases covering every counter mode, every `D` boundary value and an enable-low window. It then flags completion so the bench can stop the run.

## Interface
- `CYCLES_PER_MODE`, default 16: cycles spent in each enabled mode phase; legal range 1..255.
- `LFSR_SEED`, default 4'b1001: initial value of the load-data LFSR; a value of 0 is replaced by 4'b0001.
- `clk`  in  1  clock; all logic on the rising edge.
- `RESET`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin one sequence; sampled only in IDLE or DONE.
- `ENABLE`  out  1  enable to DUT and scoreboard.
- `MODO`  out  2  mode to DUT and scoreboard: 00 = +3, 01 = -1, 10 = +1, 11 = load.
- `D`  out  4  data or current-value stimulus.
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  high in DONE; held until the next `start` or `RESET`.
- `phase`  out  3  current state code, for waveform and debug use.

## Operation
- All outputs are registered.
- Reset values: `ENABLE` = 0, `MODO` = 00, `D` = 0, `busy` = 0, `done` = 0, `phase` = IDLE (0).
- On reset, the LFSR reloads with the seed and the cycle and index counters clear.
- States and their `phase` codes: IDLE = 0, LOAD = 1, UP3 = 2, DOWN1 = 3, UP1 = 4, DIS = 5, DONE = 6.
- IDLE or DONE with `start` = 1 -> LOAD. `done` clears and `busy` sets on the same edge.
- LOAD: `ENABLE` = 1, `MODO` = 11, `D` = LFSR value. The LFSR advances every LOAD cycle: next = {lfsr[2:0], lfsr[3]^lfsr[2]}.
- UP3, DOWN1 and UP1 use `MODO` = 00, 01 and 10 respectively, with `ENABLE` = 1 and `D` = index.
  - The index is 4 bits and clears to 0 on entry to each of these phases.
  - It increments by 1 each cycle and wraps 15 -> 0.
  - With `CYCLES_PER_MODE` >= 16, every `D` value is covered, including the scoreboard boundaries 0, 11, 12 and 15.
- Each enabled phase lasts exactly `CYCLES_PER_MODE` cycles, counted by an 8-bit cycle counter that clears on each phase entry.
- DIS: `ENABLE` = 0, `MODO` = 11, `D` = LFSR value with the LFSR still advancing. Lasts exactly 4 cycles, then -> DONE.
  - This phase checks that the scoreboard drives high-Z and the DUT holds its output while disabled.
- DONE: `ENABLE` = 0, `MODO` = 00, `D` = 0, `busy` = 0, `done` = 1.
- The LFSR is not reseeded between sequences; each new run continues the pseudo-random stream. Only `RESET` reseeds it.
- `start` while `busy` = 1 is ignored; there is no restart mid-sequence.
- `start` held high in DONE starts a new sequence on the next edge (back-to-back runs).
- `RESET` mid-sequence -> IDLE on that edge with reset values; no partial phase completes.

## Timing
- Edge k samples `start` = 1 in IDLE. The outputs after edge k are the first LOAD stimulus (`D` = seed).
- Phase boundaries are contiguous with no idle cycle between them. Stimulus changes only right after a rising edge, so it is stable a full cycle for DUT and scoreboard sampling.
- Sequence length = 4*`CYCLES_PER_MODE` + 4 cycles with `busy` = 1. With N = 16 that is 68 cycles.
- After the last DIS cycle, the next edge enters DONE: `done` = 1 and `busy` = 0 on the same edge.
- `phase` changes on the same edge as `MODO`/`ENABLE`.

## Test plan
- Reset then `start` pulse, N = 16, seed 1001 -> LOAD cycles show `D` = 1001, 0011, 0110, 1101, 1010, … with `MODO` = 11 and `ENABLE` = 1 for 16 cycles.
- Same run -> UP3 shows `D` = 0..15 with `MODO` = 00, then DOWN1 shows 0..15 with 01, then UP1 shows 0..15 with 10. Each phase is exactly 16 cycles.
- Same run -> DIS has 4 cycles of `ENABLE` = 0. `done` rises exactly 68 cycles after the first LOAD cycle, and `busy` falls on the same edge.
- `start` pulsed during UP3 -> no effect; sequence length is still 68 cycles.
- `RESET` asserted in DOWN1 -> next cycle all outputs are reset values. A following `start` gives a first LOAD `D` = 1001 (reseeded).
- N = 20 -> the count-phase index wraps: `D` = 0..15 then 0..3. `LFSR_SEED` = 0 -> first LOAD `D` = 0001.
